// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: turns the hazard unit's code into stage enables,
// IF/ID flush and ID/EX bubble, and tracks cache-miss stalls and perf counters.
module pipeline_ctrl #(
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 1,
  parameter int MISS_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       hazType,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             miss_err
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TW = $clog2(MISS_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FLUSH     = 2'd1,
    MISS_WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [FW-1:0] fl_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          front_en;
  logic          back_en;

  // front_en drives PC and IF/ID; back_en drives ID/EX, EX/MEM, MEM/WB.
  always_comb begin
    front_en    = 1'b0;
    back_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          case (hazType)
            2'b00: begin
              front_en = 1'b1;
              back_en  = 1'b1;
            end
            2'b01: begin
              back_en     = 1'b1;
              idex_bubble = 1'b1;
            end
            2'b10: begin
              front_en   = 1'b1;
              back_en    = 1'b1;
              ifid_flush = 1'b1;
            end
            default: ;
          endcase
        end
        FLUSH: begin
          if (hazType != 2'b11) begin
            front_en   = 1'b1;
            back_en    = 1'b1;
            ifid_flush = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_en    = front_en;
  assign ifid_en  = front_en;
  assign idex_en  = back_en;
  assign exmem_en = back_en;
  assign memwb_en = back_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      fl_cnt    <= '0;
      tmo_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      miss_cnt  <= '0;
      miss_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          case (hazType)
            2'b01: if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            2'b10: begin
              if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
              if (FLUSH_CYCLES > 1) begin
                state  <= FLUSH;
                fl_cnt <= FW'(FLUSH_CYCLES - 1);
              end
            end
            2'b11: begin
              state   <= MISS_WAIT;
              tmo_cnt <= '0;
            end
            default: ;
          endcase
        end
        FLUSH: begin
          // A miss drops whatever flush cycles remain.
          if (hazType == 2'b11) begin
            state   <= MISS_WAIT;
            tmo_cnt <= '0;
            fl_cnt  <= '0;
          end else begin
            fl_cnt <= fl_cnt - 1'b1;
            if (fl_cnt <= FW'(1)) state <= RUN;
          end
        end
        MISS_WAIT: begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
          if (tmo_cnt != TW'(MISS_TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_cnt >= TW'(MISS_TIMEOUT - 1)) miss_err <= 1'b1;
          if (mem_ready) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
